bram_dp_clr: RTL and testbench

//  Parametrised simple-dual-port word RAM (1 write port, 1 read port) with byte enables for FIR tap/data storage.

---
 rtl/bram_dp_clr_if.sv | 27 ++
 rtl/bram_dp_clr.sv | 129 ++++++++++++
 tb/tb_bram_dp_clr.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bram_dp_clr_if.sv
// Port bundle for bram_dp_clr: write port, read port, clear request and status.
interface bram_dp_clr_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
);
   logic                  clr_req;
   logic                  busy;
   logic                  wr_en;
   logic [DATA_W/8-1:0]   wr_be;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_di;
   logic                  rd_en;
   logic [ADDR_W-1:0]     rd_addr;
   logic [DATA_W-1:0]     rd_do;
   logic                  rd_valid;
   logic                  rd_oob;
   logic                  wr_oob;

   modport master (
      output clr_req, wr_en, wr_be, wr_addr, wr_di, rd_en, rd_addr,
      input  busy, rd_do, rd_valid, rd_oob, wr_oob
   );
   modport slave (
      input  clr_req, wr_en, wr_be, wr_addr, wr_di, rd_en, rd_addr,
      output busy, rd_do, rd_valid, rd_oob, wr_oob
   );
endinterface

// File: rtl/bram_dp_clr.sv
// Simple dual-port word RAM with byte enables, a one-word-per-cycle clear engine,
// 1 or 2 cycle read latency and out-of-range flagging.
module bram_dp_clr #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 11,
   parameter int ADDR_W   = 12,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0
) (
   input  logic          CLK,
   input  logic          Resetn,
   bram_dp_clr_if.slave  bus
);
   localparam int NB    = DATA_W / 8;
   localparam int BSH   = $clog2(NB);
   localparam int IDX_W = ADDR_W - BSH;
   localparam int MA_W  = $clog2(DEPTH);
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t            state, state_nx;
   logic [MA_W-1:0]   cnt, cnt_nx;
   logic              clr_we;

   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [MA_W-1:0]   wr_ia, rd_ia;
   logic              wr_oob_c, rd_oob_c, wr_acc, rd_acc, wr_mem;
   logic [DATA_W-1:0] rd_word, rd_data0;
   logic              wr_oob_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [RD_LAT-1:0]             vld_pipe, oob_pipe;
   logic [RD_LAT-1:0][DATA_W-1:0] dat_pipe;

   assign wr_idx   = bus.wr_addr[ADDR_W-1:BSH];
   assign rd_idx   = bus.rd_addr[ADDR_W-1:BSH];
   assign wr_ia    = wr_idx[MA_W-1:0];
   assign rd_ia    = rd_idx[MA_W-1:0];
   assign wr_oob_c = 32'(wr_idx) >= DEPTH_U;
   assign rd_oob_c = 32'(rd_idx) >= DEPTH_U;
   assign wr_acc   = Resetn && (state == RUN) && bus.wr_en;
   assign rd_acc   = Resetn && (state == RUN) && bus.rd_en;
   assign wr_mem   = wr_acc && !wr_oob_c;

   generate
      if (BSH > 0) begin : g_lsb
         logic unused_lsb;
         assign unused_lsb = ^{bus.wr_addr[BSH-1:0], bus.rd_addr[BSH-1:0]};
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!Resetn) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      clr_we   = 1'b0;
      case (state)
         CLEAR: begin
            clr_we = Resetn;
            cnt_nx = cnt + 1'b1;
            if (cnt == MA_W'(DEPTH - 1)) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end
         end
         RUN: begin
            if (bus.clr_req) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
            end
         end
         default: ;
      endcase
   end

   // Clear owns the array while active; port writes are already gated off by state.
   always_ff @(posedge CLK) begin
      if (clr_we)
         mem[cnt] <= '0;
      else if (wr_mem)
         for (int b = 0; b < NB; b++)
            if (bus.wr_be[b]) mem[wr_ia][8*b +: 8] <= bus.wr_di[8*b +: 8];
   end

   assign rd_word = rd_oob_c ? '0 : mem[rd_ia];

   always_comb begin
      rd_data0 = rd_word;
      if (RDW_MODE == 1 && wr_mem && !rd_oob_c && wr_idx == rd_idx)
         for (int b = 0; b < NB; b++)
            if (bus.wr_be[b]) rd_data0[8*b +: 8] = bus.wr_di[8*b +: 8];
   end

   always_ff @(posedge CLK) begin
      if (!Resetn) begin
         vld_pipe <= '0;
         oob_pipe <= '0;
         dat_pipe <= '0;
         wr_oob_q <= 1'b0;
      end else begin
         vld_pipe[0] <= rd_acc;
         oob_pipe[0] <= rd_acc && rd_oob_c;
         dat_pipe[0] <= rd_acc ? rd_data0 : '0;
         for (int s = 1; s < RD_LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            oob_pipe[s] <= oob_pipe[s-1];
            dat_pipe[s] <= dat_pipe[s-1];
         end
         wr_oob_q <= wr_acc && wr_oob_c;
      end
   end

   assign bus.busy     = !Resetn || (state == CLEAR);
   assign bus.rd_valid = vld_pipe[RD_LAT-1];
   assign bus.rd_oob   = vld_pipe[RD_LAT-1] && oob_pipe[RD_LAT-1];
   assign bus.rd_do    = vld_pipe[RD_LAT-1] ? dat_pipe[RD_LAT-1] : '0;
   assign bus.wr_oob   = wr_oob_q;
endmodule

// File: tb/tb_bram_dp_clr.sv
// Bench for bram_dp_clr: one instance with RD_LAT=1/old-data, one with RD_LAT=2/new-data,
// driven identically and checked against a word model through per-instance scoreboards.
module tb_bram_dp_clr;
   logic CLK = 1'b0;
   logic Resetn = 1'b0;
   always #5 CLK = ~CLK;

   bram_dp_clr_if b0();
   bram_dp_clr_if b1();

   assign b1.clr_req = b0.clr_req;
   assign b1.wr_en   = b0.wr_en;
   assign b1.wr_be   = b0.wr_be;
   assign b1.wr_addr = b0.wr_addr;
   assign b1.wr_di   = b0.wr_di;
   assign b1.rd_en   = b0.rd_en;
   assign b1.rd_addr = b0.rd_addr;

   bram_dp_clr #(.RD_LAT(1), .RDW_MODE(0)) dut0 (.CLK(CLK), .Resetn(Resetn), .bus(b0.slave));
   bram_dp_clr #(.RD_LAT(2), .RDW_MODE(1)) dut1 (.CLK(CLK), .Resetn(Resetn), .bus(b1.slave));

   typedef struct {
      logic [31:0] d;
      logic        oob;
      int          due;
   } exp_t;

   exp_t        q0[$], q1[$];
   logic [31:0] mem [11];
   int          n_chk = 0, n_fail = 0, cyc = 0;
   bit          mon = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (mon) begin
         if (b0.rd_valid) begin
            if (q0.size() == 0) chk("rd_unexpected0", 1, 0);
            else begin
               e = q0.pop_front();
               chk("rd_do0", b0.rd_do, e.d);
               chk("rd_oob0", b0.rd_oob, e.oob);
               chk("rd_cycle0", cyc, e.due);
            end
         end else chk("rd_idle0", {b0.rd_oob, b0.rd_do}, 0);
         if (b1.rd_valid) begin
            if (q1.size() == 0) chk("rd_unexpected1", 1, 0);
            else begin
               e = q1.pop_front();
               chk("rd_do1", b1.rd_do, e.d);
               chk("rd_oob1", b1.rd_oob, e.oob);
               chk("rd_cycle1", cyc, e.due);
            end
         end else chk("rd_idle1", {b1.rd_oob, b1.rd_do}, 0);
      end
   end

   task automatic idle();
      b0.clr_req = 0; b0.wr_en = 0; b0.wr_be = '0; b0.wr_addr = '0;
      b0.wr_di = '0; b0.rd_en = 0; b0.rd_addr = '0;
   endtask

   // One cycle of stimulus; expectations are taken from the model before the write lands.
   task automatic op(input logic we, input logic [3:0] be, input logic [11:0] wa,
                     input logic [31:0] wd, input logic re, input logic [11:0] ra,
                     input logic clr);
      exp_t e0, e1;
      int wi, ri;
      wi = int'(wa >> 2);
      ri = int'(ra >> 2);
      b0.wr_en = we; b0.wr_be = be; b0.wr_addr = wa; b0.wr_di = wd;
      b0.rd_en = re; b0.rd_addr = ra; b0.clr_req = clr;
      if (re) begin
         e0.oob = (ri >= 11);
         e0.d   = e0.oob ? 32'h0 : mem[ri];
         e0.due = cyc + 1;
         e1     = e0;
         e1.due = cyc + 2;
         if (we && wi == ri && !e0.oob)
            for (int b = 0; b < 4; b++) if (be[b]) e1.d[8*b +: 8] = wd[8*b +: 8];
         q0.push_back(e0);
         q1.push_back(e1);
      end
      if (we && wi < 11)
         for (int b = 0; b < 4; b++) if (be[b]) mem[wi][8*b +: 8] = wd[8*b +: 8];
      if (clr) for (int w = 0; w < 11; w++) mem[w] = 32'h0;
      @(posedge CLK); #1;
      idle();
   endtask

   // Release reset with junk on every port and count busy cycles; junk drops after the clear.
   task automatic rel_count(input string tag);
      int n0, n1;
      n0 = 0; n1 = 0;
      Resetn = 1'b1;
      b0.wr_en = 1; b0.wr_be = 4'hF; b0.wr_addr = 12'h000; b0.wr_di = 32'hDEADBEEF;
      b0.rd_en = 1; b0.rd_addr = 12'h000; b0.clr_req = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (i == 11) idle();
         n0 += int'(b0.busy);
         n1 += int'(b1.busy);
      end
      chk({tag, "_busy_cycles0"}, n0, 11);
      chk({tag, "_busy_cycles1"}, n1, 11);
      for (int w = 0; w < 11; w++) mem[w] = 32'h0;
      @(posedge CLK); #1;
   endtask

   task automatic stream();
      for (int i = 0; i < 11; i++) op(0, 4'h0, 12'h0, 32'h0, 1, 12'(i * 4), 0);
   endtask

   initial begin
      logic [11:0] wa, ra;
      idle();
      for (int w = 0; w < 11; w++) mem[w] = 32'h0;
      Resetn = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", {b1.busy, b0.busy}, 2'b11);
      chk("rst_out0", {b0.rd_valid, b0.rd_oob, b0.wr_oob, b0.rd_do}, 0);
      chk("rst_out1", {b1.rd_valid, b1.rd_oob, b1.wr_oob, b1.rd_do}, 0);
      mon = 1'b1;
      rel_count("rst");
      stream();

      op(1, 4'hF, 12'h008, 32'hAABBCCDD, 0, 12'h0, 0);
      op(1, 4'h5, 12'h008, 32'h11223344, 0, 12'h0, 0);
      op(0, 4'h0, 12'h000, 32'h0, 1, 12'h008, 0);

      op(1, 4'hF, 12'h004, 32'h1, 0, 12'h0, 0);
      op(1, 4'hF, 12'h004, 32'h2, 1, 12'h004, 0);
      op(1, 4'h2, 12'h004, 32'hFFFFFFFF, 1, 12'h004, 0);
      op(0, 4'h0, 12'h000, 32'h0, 1, 12'h004, 0);

      op(1, 4'hF, 12'h028, 32'h12345678, 0, 12'h0, 0);
      @(negedge CLK);
      chk("wr_oob_inrange", {b1.wr_oob, b0.wr_oob}, 2'b00);
      @(posedge CLK); #1;
      op(1, 4'hF, 12'h02C, 32'hFFFFFFFF, 0, 12'h0, 0);
      @(negedge CLK);
      chk("wr_oob_pulse", {b1.wr_oob, b0.wr_oob}, 2'b11);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("wr_oob_drop", {b1.wr_oob, b0.wr_oob}, 2'b00);
      @(posedge CLK); #1;
      op(0, 4'h0, 12'h000, 32'h0, 1, 12'h02C, 0);
      op(0, 4'h0, 12'h000, 32'h0, 1, 12'h02B, 0);
      op(0, 4'h0, 12'h000, 32'h0, 1, 12'h02F, 0);

      for (int i = 0; i < 60; i++) begin
         wa = 12'($urandom_range(0, 47));
         ra = 12'($urandom_range(0, 47));
         if (i % 5 == 0) ra = wa;
         op(1'($urandom), 4'($urandom), wa, $urandom, 1'($urandom), ra, 0);
      end

      op(1, 4'hF, 12'h00C, 32'hCAFE0001, 1, 12'h008, 1);
      @(negedge CLK);
      chk("sclr_busy", {b1.busy, b0.busy}, 2'b11);
      @(posedge CLK); #1;
      repeat (3) begin @(posedge CLK); #1; end
      Resetn = 1'b0;
      repeat (2) begin @(posedge CLK); #1; end
      rel_count("sclr");
      stream();

      repeat (4) @(posedge CLK);
      #1;
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
